// File: rtl/mac_echo_responder.sv
// Store-and-forward MAC loopback: buffers rx frames, drops runts, oversize frames
// and overflow, and re-emits each good frame with dst/src MAC addresses swapped.
module mac_echo_responder #(
    parameter int FIFO_DEPTH      = 512,
    parameter int MAX_FRAME_WORDS = 190
) (
    input  logic        clk156,
    input  logic        areset_n,
    input  logic        enable,
    input  logic        mac_rx_axis_tvalid,
    output logic        mac_rx_axis_tready,
    input  logic [63:0] mac_rx_axis_tdata,
    input  logic [7:0]  mac_rx_axis_tkeep,
    input  logic        mac_rx_axis_tlast,
    output logic        mac_tx_axis_tvalid,
    input  logic        mac_tx_axis_tready,
    output logic [63:0] mac_tx_axis_tdata,
    output logic [7:0]  mac_tx_axis_tkeep,
    output logic        mac_tx_axis_tlast,
    output logic [31:0] frames_echoed,
    output logic [31:0] frames_dropped,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(MAX_FRAME_WORDS + 1) + 1;
    localparam logic [PW-1:0] DEPTH_P   = PW'(FIFO_DEPTH);
    localparam logic [BW-1:0] MAX_BEATS = BW'(MAX_FRAME_WORDS);

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } word_t;

    typedef enum logic [1:0] {RX_IDLE, RX_STORE, RX_DISCARD} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_LOAD0, TX_LOAD1, TX_HDR0, TX_HDR1, TX_BODY} tx_state_t;

    word_t           mem [FIFO_DEPTH];
    word_t           rx_word, rd_q, hdr0_q, hdr1_q, tx_word;
    word_t           pf [2];
    logic [PW-1:0]   wr_ptr, commit_ptr, rd_ptr, frame_cnt;
    logic [PW-1:0]   wr_ptr_nx, commit_ptr_nx;
    logic [BW-1:0]   beat_idx, beat_idx_nx;
    rx_state_t       rx_state, rx_state_nx;
    tx_state_t       tx_state, tx_state_nx;
    logic            rx_ready_q, rx_hs, full, too_long, runt;
    logic            wr_en, commit, drop;
    logic            rd_en, rd_vld, last_seen, can_read, room;
    logic            push, pop, tx_valid, tx_hs, tx_done;
    logic            pf_wp, pf_rp;
    logic [1:0]      pf_cnt;

    assign rx_word  = {mac_rx_axis_tlast, mac_rx_axis_tkeep, mac_rx_axis_tdata};
    assign rx_hs    = mac_rx_axis_tvalid & rx_ready_q;
    assign full     = (wr_ptr - rd_ptr) == DEPTH_P;
    assign too_long = beat_idx >= MAX_BEATS;
    // Under 14 bytes only happens on a 1-beat frame or a 2-beat frame with < 6 bytes in beat 1.
    assign runt     = (beat_idx == '0) || (beat_idx == BW'(1) && $countones(mac_rx_axis_tkeep) < 6);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        rx_state_nx   = rx_state;
        wr_ptr_nx     = wr_ptr;
        commit_ptr_nx = commit_ptr;
        beat_idx_nx   = beat_idx;
        wr_en         = 1'b0;
        commit        = 1'b0;
        drop          = 1'b0;
        case (rx_state)
            RX_IDLE, RX_STORE: begin
                if (rx_hs) begin
                    if (rx_state == RX_IDLE && !enable) begin
                        drop        = 1'b1;
                        rx_state_nx = mac_rx_axis_tlast ? RX_IDLE : RX_DISCARD;
                    end else if (full || too_long) begin
                        drop        = 1'b1;
                        wr_ptr_nx   = commit_ptr;
                        beat_idx_nx = '0;
                        rx_state_nx = mac_rx_axis_tlast ? RX_IDLE : RX_DISCARD;
                    end else begin
                        wr_en = 1'b1;
                        if (mac_rx_axis_tlast) begin
                            beat_idx_nx = '0;
                            rx_state_nx = RX_IDLE;
                            if (runt) begin
                                drop      = 1'b1;
                                wr_ptr_nx = commit_ptr;
                            end else begin
                                commit        = 1'b1;
                                wr_ptr_nx     = wr_ptr + PW'(1);
                                commit_ptr_nx = wr_ptr + PW'(1);
                            end
                        end else begin
                            wr_ptr_nx   = wr_ptr + PW'(1);
                            beat_idx_nx = beat_idx + BW'(1);
                            rx_state_nx = RX_STORE;
                        end
                    end
                end
            end
            RX_DISCARD: if (rx_hs && mac_rx_axis_tlast) rx_state_nx = RX_IDLE;
            default:    rx_state_nx = RX_IDLE;
        endcase
    end

    assign push     = rd_vld && (tx_state inside {TX_HDR0, TX_HDR1, TX_BODY});
    assign can_read = !last_seen && !(rd_vld && rd_q.last);
    // A read issued now lands next cycle; keep total prefetch occupancy at two.
    assign room     = ({1'b0, pf_cnt} + {2'b00, push}) <= (3'd1 + {2'b00, pop});

    always_comb begin
        tx_state_nx = tx_state;
        tx_word     = '0;
        tx_valid    = 1'b0;
        rd_en       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                rd_en = frame_cnt != '0;
                if (rd_en) tx_state_nx = TX_LOAD0;
            end
            TX_LOAD0: begin
                rd_en       = can_read && room;
                tx_state_nx = TX_LOAD1;
            end
            TX_LOAD1: begin
                rd_en       = can_read && room;
                tx_state_nx = TX_HDR0;
            end
            TX_HDR0: begin
                rd_en    = can_read && room;
                tx_valid = 1'b1;
                tx_word  = hdr0_q;
                if (mac_tx_axis_tready) tx_state_nx = TX_HDR1;
            end
            TX_HDR1: begin
                rd_en    = can_read && room;
                tx_valid = 1'b1;
                tx_word  = hdr1_q;
                if (mac_tx_axis_tready) tx_state_nx = hdr1_q.last ? TX_IDLE : TX_BODY;
            end
            TX_BODY: begin
                rd_en    = can_read && room;
                tx_valid = pf_cnt != 2'd0;
                tx_word  = tx_valid ? pf[pf_rp] : '0;
                if (tx_valid && mac_tx_axis_tready && tx_word.last) tx_state_nx = TX_IDLE;
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    assign tx_hs   = tx_valid && mac_tx_axis_tready;
    assign pop     = tx_hs && (tx_state == TX_BODY);
    assign tx_done = tx_hs && tx_word.last;

    // NOTE: the frame RAM and prefetch slots carry no reset; pointers and valid flags define their contents.
    always_ff @(posedge clk156) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_word;
        if (rd_en) rd_q <= mem[rd_ptr[AW-1:0]];
        if (push)  pf[pf_wp] <= rd_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk156 or negedge areset_n) begin
        if (!areset_n) begin
            rx_ready_q     <= 1'b0;
            rx_state       <= RX_IDLE;
            tx_state       <= TX_IDLE;
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            rd_ptr         <= '0;
            beat_idx       <= '0;
            frame_cnt      <= '0;
            rd_vld         <= 1'b0;
            last_seen      <= 1'b0;
            hdr0_q         <= '0;
            hdr1_q         <= '0;
            pf_wp          <= 1'b0;
            pf_rp          <= 1'b0;
            pf_cnt         <= 2'd0;
            frames_echoed  <= '0;
            frames_dropped <= '0;
        end else begin
            rx_ready_q <= 1'b1;
            rx_state   <= rx_state_nx;
            tx_state   <= tx_state_nx;
            wr_ptr     <= wr_ptr_nx;
            commit_ptr <= commit_ptr_nx;
            beat_idx   <= beat_idx_nx;
            rd_vld     <= rd_en;
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);

            if (tx_state == TX_IDLE && rd_en) last_seen <= 1'b0;
            else if (rd_vld && rd_q.last)     last_seen <= 1'b1;

            if (tx_state == TX_LOAD0) hdr0_q <= rd_q;
            if (tx_state == TX_LOAD1) begin
                hdr0_q <= '{last: hdr0_q.last, keep: hdr0_q.keep,
                            data: {hdr0_q.data[15:0], rd_q.data[31:0], hdr0_q.data[63:48]}};
                hdr1_q <= '{last: rd_q.last, keep: rd_q.keep,
                            data: {rd_q.data[63:32], hdr0_q.data[47:16]}};
            end

            if (push) pf_wp <= ~pf_wp;
            if (pop)  pf_rp <= ~pf_rp;
            pf_cnt <= pf_cnt + {1'b0, push} - {1'b0, pop};

            case ({commit, tx_done})
                2'b10:   frame_cnt <= frame_cnt + PW'(1);
                2'b01:   frame_cnt <= frame_cnt - PW'(1);
                default: frame_cnt <= frame_cnt;
            endcase

            if (tx_done && frames_echoed != 32'hFFFF_FFFF) frames_echoed  <= frames_echoed + 32'd1;
            if (drop && frames_dropped != 32'hFFFF_FFFF)   frames_dropped <= frames_dropped + 32'd1;
        end
    end

    assign mac_rx_axis_tready = rx_ready_q;
    assign mac_tx_axis_tvalid = tx_valid;
    assign mac_tx_axis_tdata  = tx_word.data;
    assign mac_tx_axis_tkeep  = tx_word.keep;
    assign mac_tx_axis_tlast  = tx_word.last;
    assign busy = (frame_cnt != '0) || (rx_state != RX_IDLE) || (tx_state != TX_IDLE);

endmodule

// File: tb/tb_mac_echo_responder.sv
// Directed bench for mac_echo_responder: expected swapped beats are queued when a
// good frame is driven and compared as the DUT emits them.
module tb_mac_echo_responder;
    localparam int FIFO_DEPTH      = 512;
    localparam int MAX_FRAME_WORDS = 190;

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    logic        clk156 = 1'b0;
    logic        areset_n;
    logic        enable;
    logic        mac_rx_axis_tvalid;
    logic        mac_rx_axis_tready;
    logic [63:0] mac_rx_axis_tdata;
    logic [7:0]  mac_rx_axis_tkeep;
    logic        mac_rx_axis_tlast;
    logic        mac_tx_axis_tvalid;
    logic        mac_tx_axis_tready;
    logic [63:0] mac_tx_axis_tdata;
    logic [7:0]  mac_tx_axis_tkeep;
    logic        mac_tx_axis_tlast;
    logic [31:0] frames_echoed;
    logic [31:0] frames_dropped;
    logic        busy;

    beat_t       sb[$];
    logic [7:0]  fb [0:2047];
    int          tests = 0;
    int          fails = 0;
    int          exp_echoed = 0;
    int          exp_dropped = 0;

    always #5 clk156 = ~clk156;

    mac_echo_responder #(
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_FRAME_WORDS (MAX_FRAME_WORDS)
    ) dut (
        .clk156             (clk156),
        .areset_n           (areset_n),
        .enable             (enable),
        .mac_rx_axis_tvalid (mac_rx_axis_tvalid),
        .mac_rx_axis_tready (mac_rx_axis_tready),
        .mac_rx_axis_tdata  (mac_rx_axis_tdata),
        .mac_rx_axis_tkeep  (mac_rx_axis_tkeep),
        .mac_rx_axis_tlast  (mac_rx_axis_tlast),
        .mac_tx_axis_tvalid (mac_tx_axis_tvalid),
        .mac_tx_axis_tready (mac_tx_axis_tready),
        .mac_tx_axis_tdata  (mac_tx_axis_tdata),
        .mac_tx_axis_tkeep  (mac_tx_axis_tkeep),
        .mac_tx_axis_tlast  (mac_tx_axis_tlast),
        .frames_echoed      (frames_echoed),
        .frames_dropped     (frames_dropped),
        .busy               (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_frame(input int nbytes, input int seed);
        for (int i = 0; i < nbytes; i++)
            fb[i] = (i < 12) ? 8'(8'h11 * i + seed) : 8'(i + seed);
    endtask

    function automatic logic [7:0] keep_for(input int rem);
        return (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
    endfunction

    function automatic logic [7:0] swapped_byte(input int j);
        if (j < 6)       return fb[j + 6];
        else if (j < 12) return fb[j - 6];
        else             return fb[j];
    endfunction

    task automatic push_expected(input int nbytes);
        int nbeats;
        beat_t e;
        nbeats = (nbytes + 7) / 8;
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < 8; l++)
                e.data[8*l +: 8] = (8*b + l < nbytes) ? swapped_byte(8*b + l) : 8'h00;
            e.keep = keep_for(nbytes - 8*b);
            e.last = (b == nbeats - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send_frame(input int nbytes, input logic en);
        int nbeats;
        nbeats = (nbytes + 7) / 8;
        enable = en;
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < 8; l++)
                mac_rx_axis_tdata[8*l +: 8] = (8*b + l < nbytes) ? fb[8*b + l] : 8'h00;
            mac_rx_axis_tkeep  = keep_for(nbytes - 8*b);
            mac_rx_axis_tlast  = (b == nbeats - 1);
            mac_rx_axis_tvalid = 1'b1;
            @(posedge clk156); #1;
        end
        mac_rx_axis_tvalid = 1'b0;
        mac_rx_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < max_cycles) begin
            @(posedge clk156); #1;
            n++;
        end
        check(tag, 128'(sb.size() == 0 && !busy), 128'(1));
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_echoed"},  128'(frames_echoed),  128'(exp_echoed));
        check({tag, "_dropped"}, 128'(frames_dropped), 128'(exp_dropped));
    endtask

    task automatic monitor();
        logic  stall;
        beat_t held, w, e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk156);
            w = {mac_tx_axis_tlast, mac_tx_axis_tkeep, mac_tx_axis_tdata};
            if (!areset_n) begin
                stall = 1'b0;
            end else begin
                if (stall) check("tx_hold", 128'({mac_tx_axis_tvalid, w}), 128'({1'b1, held}));
                if (mac_tx_axis_tvalid && mac_tx_axis_tready) begin
                    check("tx_beat_expected", 128'(sb.size() != 0), 128'(1));
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("tx_beat", 128'(w), 128'(e));
                    end
                end
                stall = mac_tx_axis_tvalid && !mac_tx_axis_tready;
                held  = w;
            end
        end
    endtask

    initial begin
        logic seen;
        areset_n           = 1'b0;
        enable             = 1'b1;
        mac_rx_axis_tvalid = 1'b0;
        mac_rx_axis_tdata  = '0;
        mac_rx_axis_tkeep  = '0;
        mac_rx_axis_tlast  = 1'b0;
        mac_tx_axis_tready = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk156);
        #1;
        check("rst_rx_tready", 128'(mac_rx_axis_tready), 128'(0));
        check("rst_tx_tvalid", 128'(mac_tx_axis_tvalid), 128'(0));
        check("rst_busy",      128'(busy),               128'(0));
        check_counters("rst");
        areset_n = 1'b1;
        @(posedge clk156); #1;
        check("rx_tready_after_reset", 128'(mac_rx_axis_tready), 128'(1));

        // 1: single 64-byte frame, latency bound
        fill_frame(64, 0);
        push_expected(64);
        send_frame(64, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!seen) begin
                @(posedge clk156); #1;
                seen = mac_tx_axis_tvalid;
            end
        end
        check("t1_latency", 128'(seen), 128'(1));
        wait_drain("t1_drain", 200);
        exp_echoed = 1;
        check_counters("t1");

        // 2: three back-to-back 61-byte frames, tready toggling
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    fill_frame(61, 10 * f + 1);
                    push_expected(61);
                    send_frame(61, 1'b1);
                end
            end
            begin
                for (int k = 0; k < 300; k++) begin
                    mac_tx_axis_tready = ~mac_tx_axis_tready;
                    @(posedge clk156); #1;
                end
                mac_tx_axis_tready = 1'b1;
            end
        join
        wait_drain("t2_drain", 500);
        exp_echoed = 4;
        check_counters("t2");

        // 3: 13-byte runt dropped, 14-byte minimum echoed
        fill_frame(13, 8'h20);
        send_frame(13, 1'b1);
        fill_frame(14, 8'h30);
        push_expected(14);
        send_frame(14, 1'b1);
        wait_drain("t3_drain", 200);
        exp_echoed  = 5;
        exp_dropped = 1;
        check_counters("t3");

        // 4: 191-beat frame dropped, following frame echoed
        fill_frame(191 * 8, 8'h40);
        send_frame(191 * 8, 1'b1);
        fill_frame(64, 8'h50);
        push_expected(64);
        send_frame(64, 1'b1);
        wait_drain("t4_drain", 400);
        exp_echoed  = 6;
        exp_dropped = 2;
        check_counters("t4");

        // 5: tx stalled, three max frames; third overflows
        mac_tx_axis_tready = 1'b0;
        fill_frame(1520, 8'h60);
        push_expected(1520);
        send_frame(1520, 1'b1);
        fill_frame(1520, 8'h61);
        push_expected(1520);
        send_frame(1520, 1'b1);
        fill_frame(1520, 8'h62);
        send_frame(1520, 1'b1);
        exp_dropped = 3;
        check_counters("t5_stalled");
        check("t5_busy", 128'(busy), 128'(1));
        mac_tx_axis_tready = 1'b1;
        wait_drain("t5_drain", 1000);
        exp_echoed = 8;
        check_counters("t5");

        // 6: enable=0 drops a frame; async reset mid-echo; post-reset frame
        fill_frame(64, 8'h70);
        send_frame(64, 1'b0);
        enable = 1'b1;
        repeat (2) @(posedge clk156);
        #1;
        exp_dropped = 4;
        check_counters("t6_disable");

        fill_frame(64, 8'h71);
        push_expected(64);
        send_frame(64, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!seen) begin
                @(posedge clk156); #1;
                seen = mac_tx_axis_tvalid;
            end
        end
        check("t6_echo_started", 128'(seen), 128'(1));
        repeat (2) @(posedge clk156);
        #1;
        areset_n = 1'b0;
        #1;
        sb.delete();
        exp_echoed  = 0;
        exp_dropped = 0;
        check("t6_rst_tvalid",    128'(mac_tx_axis_tvalid), 128'(0));
        check("t6_rst_rx_tready", 128'(mac_rx_axis_tready), 128'(0));
        check("t6_rst_busy",      128'(busy),               128'(0));
        check_counters("t6_rst");
        repeat (2) @(posedge clk156);
        #1;
        areset_n = 1'b1;
        @(posedge clk156); #1;
        fill_frame(64, 8'h72);
        push_expected(64);
        send_frame(64, 1'b1);
        wait_drain("t6_drain", 200);
        exp_echoed = 1;
        check_counters("t6_post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_echo_responder.md
Name: mac_echo_responder

Overview:
Far-end MAC-side responder for the 64-bit AXI-Stream MAC interface used between server and client in system test. Accepts frames on mac_rx_axis and buffers them store-and-forward. Each good frame is re-emitted on mac_tx_axis with Ethernet destination and source MAC addresses swapped, which closes the loop for a single UDT endpoint without a second core.

Parameters:
FIFO_DEPTH, 512, data buffer depth in 64-bit words; power of 2, >= 2*MAX_FRAME_WORDS
MAX_FRAME_WORDS, 190, longest accepted frame in beats (1518 bytes)

Ports:
clk156  input  1  sole clock
areset_n  input  1  asynchronous active-low reset
enable  input  1  1 = echo frames; sampled at the first beat of each rx frame
mac_rx_axis_tvalid  input  1  rx beat valid
mac_rx_axis_tready  output  1  rx ready
mac_rx_axis_tdata  input  64  rx data; lane i = tdata[8i+7:8i], lane 0 = first byte
mac_rx_axis_tkeep  input  8  rx byte enables, contiguous from lane 0
mac_rx_axis_tlast  input  1  rx end of frame
mac_tx_axis_tvalid  output  1  tx beat valid
mac_tx_axis_tready  input  1  tx ready
mac_tx_axis_tdata  output  64  tx data
mac_tx_axis_tkeep  output  8  tx byte enables
mac_tx_axis_tlast  output  1  tx end of frame
frames_echoed  output  32  count of frames fully transmitted
frames_dropped  output  32  count of rx frames discarded
busy  output  1  1 while any committed frame or partial rx frame is held

Behaviour:
- Reset: every output 0 (including mac_rx_axis_tready), all pointers/counters/FSMs cleared; buffered frames lost. The first clock after release drives mac_rx_axis_tready=1 and holds it at 1 permanently. Overflow is handled by dropping, never by stalling.
- Buffer: circular RAM, 73-bit words {tlast, tkeep, tdata}; wr_ptr (speculative), commit_ptr, rd_ptr; pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- RX FSM states: IDLE, STORE, DISCARD.
  - IDLE: on the first beat, go to DISCARD if enable=0. Otherwise write the beat and go to STORE, or commit/drop immediately if tlast=1.
  - STORE: write each beat. On any beat where the buffer is full (wr_ptr-rd_ptr == FIFO_DEPTH) or the beat count would exceed MAX_FRAME_WORDS, go to DISCARD and rewind wr_ptr to commit_ptr.
  - DISCARD: accept beats without writing. Return to IDLE after tlast.
  - Any path into DISCARD, or a runt at tlast, increments frames_dropped once per frame.
- Runt: total bytes < 14 (bytes = 8*(beats-1) + popcount(tkeep on last beat)). A runt is rewound at tlast and dropped.
- Commit: on a good tlast handshake, commit_ptr <= wr_ptr+1 and frame_cnt++.
- TX FSM states: IDLE, LOAD0, LOAD1, HDR0, HDR1, BODY.
  - Leave IDLE when frame_cnt>0. LOAD0 and LOAD1 read beats 0 and 1 (RAM read latency 1) into registers.
  - HDR0 and HDR1 present the swapped beats. BODY streams remaining beats at 1 beat/clock while tready=1, using a 2-entry prefetch buffer.
  - On the tlast handshake: frame_cnt--, frames_echoed++, return to IDLE.
- Swap rule: out byte j = in byte j+6 for j in 0..5; in byte j-6 for j in 6..11; otherwise unchanged. tkeep/tlast pass through unchanged. A 14-byte frame ends at HDR1 with tlast.
- AXIS: once tx tvalid=1, tdata/tkeep/tlast hold until tready=1. tvalid never drops mid-frame while data is buffered.
- Latency: with TX idle, tx tvalid for beat 0 is asserted by cycle 4 after the committing rx tlast handshake. The inter-frame gap is ≤3 idle cycles.
- Simultaneous commit and tx tlast handshake in the same cycle: frame_cnt unchanged.
- rd_ptr advances as words are read, freeing space immediately.
- Counters saturate at 32'hFFFF_FFFF.
- busy = (frame_cnt != 0) | (RX FSM != IDLE) | (TX FSM != IDLE).

Test Plan:
1. enable=1; 64-byte frame, dst 00:11:22:33:44:55, src 66:77:88:99:AA:BB, bytes 12..63 = 0x0C..0x3F -> 8 tx beats; bytes 0..11 = 66 77 88 99 AA BB 00 11 22 33 44 55; rest identical; last tkeep=FF; frames_echoed=1.
2. Three back-to-back 61-byte frames, tx tready toggling 1/0 each cycle -> three identical swapped frames; last tkeep=1F; no loss or duplication; frames_echoed=3.
3. 13-byte frame, then 14-byte frame -> frames_dropped=1; only the 14-byte frame echoed (2 beats, last tkeep=3F).
4. Frame of 191 beats, then 64-byte frame -> first dropped, second echoed; frames_dropped=1.
5. tx tready=0, FIFO_DEPTH=512; send 190-beat frames continuously -> frames 1-2 committed, frame 3 dropped at overflow; after tready=1, frames 1-2 echoed intact.
6. enable=0 for one frame, then 1 -> that frame dropped. Assert areset_n=0 mid-echo -> tvalid=0, counters=0 at once. A post-reset frame echoes correctly.
